// File: rtl/layer_controller.sv
// -----------------------------------------------------------------------------
// layer_controller
//
// Sequencing controller for a layer-multiplexed network datapath. It latches a
// network input activation vector, then loops LAYER_MAX times over one shared
// layer module:
//   GET_LAYER : wait for the layer sequencer to confirm the layer is configured
//   SEND      : present the current activations (zero-extended) to the layer
//   RECV      : capture the raw neuron sums and convert them to activations
//               (ReLU with saturation) for the next pass
// After the last pass the final activations remain visible on layer_inputs
// until the next start vector is accepted.
//
// Ports (all vectors are lane 0 at the LSBs):
//   clk, rst                   : clock, synchronous active-high reset
//   start_inputs[_valid/_ready]: network input activations (unsigned lanes)
//   layer_number[_valid/_ready]: layer-setup token from the layer sequencer
//   layer_outputs[_valid/_ready]: signed neuron sums from the layer module
//   layer_inputs[_valid/_ready]: activations presented to the layer module
//
// Every handshake output is decoded from the registered state only; reset
// additionally forces them low while it is asserted.
// -----------------------------------------------------------------------------
module layer_controller #(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int LAYER_ADDR_WIDTH    = 1,
  parameter int LAYER_MAX           = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,

  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]    start_inputs,
  input  logic                                      start_inputs_valid,
  output logic                                      start_inputs_ready,

  input  logic [LAYER_ADDR_WIDTH-1:0]               layer_number,
  input  logic                                      layer_number_valid,
  output logic                                      layer_number_ready,

  input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] layer_outputs,
  input  logic                                      layer_outputs_valid,
  output logic                                      layer_outputs_ready,

  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] layer_inputs,
  output logic                                      layer_inputs_valid,
  input  logic                                      layer_inputs_ready
);

  localparam int NOW   = NEURON_OUTPUT_WIDTH;
  localparam int AW    = ACTIVATION_WIDTH;
  localparam int NOW1  = NOW + 1;
  localparam int CNT_W = $clog2(LAYER_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAYER_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Largest representable activation, held one bit wider than a neuron sum so
  // the limit stays exact even when AW equals NOW.
  localparam logic [NOW:0] SAT_LIM = NOW1'((64'd1 << AW) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_LAYER,
    ST_SEND,
    ST_RECV
  } state_t;

  state_t                         state_q, state_d;
  logic [NEURON_NUM-1:0][AW-1:0]  act_buf_q, act_buf_d;
  logic [CNT_W-1:0]               layer_cnt_q, layer_cnt_d;
  // Layer token is captured for observability only; it does not steer anything.
  logic [LAYER_ADDR_WIDTH-1:0]    layer_id_unused_q, layer_id_unused_d;

  // ReLU with saturation on a signed neuron sum.
  function automatic logic [AW-1:0] relu_sat(input logic [NOW-1:0] x);
    logic [AW-1:0] r;
    if (x[NOW-1]) begin
      r = '0;
    end else if ({1'b0, x} > SAT_LIM) begin
      r = '1;
    end else begin
      r = x[AW-1:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      act_buf_q         <= '0;
      layer_cnt_q       <= '0;
      layer_id_unused_q <= '0;
    end else begin
      state_q           <= state_d;
      act_buf_q         <= act_buf_d;
      layer_cnt_q       <= layer_cnt_d;
      layer_id_unused_q <= layer_id_unused_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d           = state_q;
    act_buf_d         = act_buf_q;
    layer_cnt_d       = layer_cnt_q;
    layer_id_unused_d = layer_id_unused_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_inputs_valid) begin
          act_buf_d   = start_inputs;
          layer_cnt_d = '0;
          state_d     = ST_GET_LAYER;
        end
      end

      ST_GET_LAYER: begin
        if (layer_number_valid) begin
          layer_id_unused_d = layer_number;
          state_d           = ST_SEND;
        end
      end

      ST_SEND: begin
        if (layer_inputs_ready) begin
          state_d = ST_RECV;
        end
      end

      ST_RECV: begin
        if (layer_outputs_valid) begin
          for (int unsigned i = 0; i < NEURON_NUM; i++) begin
            act_buf_d[i] = relu_sat(layer_outputs[i*NOW +: NOW]);
          end
          layer_cnt_d = layer_cnt_q + CNT_ONE;
          state_d     = (layer_cnt_d == CNT_LAST) ? ST_IDLE : ST_GET_LAYER;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs: one per state, suppressed while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    start_inputs_ready  = 1'b0;
    layer_number_ready  = 1'b0;
    layer_inputs_valid  = 1'b0;
    layer_outputs_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE:      start_inputs_ready  = 1'b1;
        ST_GET_LAYER: layer_number_ready  = 1'b1;
        ST_SEND:      layer_inputs_valid  = 1'b1;
        ST_RECV:      layer_outputs_ready = 1'b1;
        default:      ;
      endcase
    end
  end

  // Activations are unsigned, so each lane is zero-extended to sum width.
  always_comb begin
    layer_inputs = '0;
    for (int unsigned i = 0; i < NEURON_NUM; i++) begin
      layer_inputs[i*NOW +: NOW] = NOW'(act_buf_q[i]);
    end
  end

endmodule

// File: tb/tb_layer_controller.sv
module tb_layer_controller;

  localparam int NN   = 5;
  localparam int NOW  = 10;
  localparam int AW   = 9;
  localparam int LAW  = 1;
  localparam int LMAX = 3;
  localparam int SNOW = 12;

  logic clk;
  logic rst;

  logic [NN*AW-1:0]  start_inputs;
  logic              start_inputs_valid, start_inputs_ready;
  logic [LAW-1:0]    layer_number;
  logic              layer_number_valid, layer_number_ready;
  logic [NN*NOW-1:0] layer_outputs;
  logic              layer_outputs_valid, layer_outputs_ready;
  logic [NN*NOW-1:0] layer_inputs;
  logic              layer_inputs_valid, layer_inputs_ready;

  // Second build with wider sums to exercise saturation.
  logic [NN*AW-1:0]   s_start_inputs;
  logic               s_start_inputs_valid, s_start_inputs_ready;
  logic [LAW-1:0]     s_layer_number;
  logic               s_layer_number_valid, s_layer_number_ready;
  logic [NN*SNOW-1:0] s_layer_outputs;
  logic               s_layer_outputs_valid, s_layer_outputs_ready;
  logic [NN*SNOW-1:0] s_layer_inputs;
  logic               s_layer_inputs_valid, s_layer_inputs_ready;

  int n_total = 0;
  int n_pass  = 0;
  int li_xfers = 0;

  int unsigned model_act [NN];
  int unsigned dir_raw   [NN] = '{428, 952, 452, 976, 476};

  layer_controller #(
    .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(NOW), .ACTIVATION_WIDTH(AW),
    .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(LMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .start_inputs(start_inputs), .start_inputs_valid(start_inputs_valid),
    .start_inputs_ready(start_inputs_ready),
    .layer_number(layer_number), .layer_number_valid(layer_number_valid),
    .layer_number_ready(layer_number_ready),
    .layer_outputs(layer_outputs), .layer_outputs_valid(layer_outputs_valid),
    .layer_outputs_ready(layer_outputs_ready),
    .layer_inputs(layer_inputs), .layer_inputs_valid(layer_inputs_valid),
    .layer_inputs_ready(layer_inputs_ready)
  );

  layer_controller #(
    .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(SNOW), .ACTIVATION_WIDTH(AW),
    .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(1)
  ) dut_sat (
    .clk(clk), .rst(rst),
    .start_inputs(s_start_inputs), .start_inputs_valid(s_start_inputs_valid),
    .start_inputs_ready(s_start_inputs_ready),
    .layer_number(s_layer_number), .layer_number_valid(s_layer_number_valid),
    .layer_number_ready(s_layer_number_ready),
    .layer_outputs(s_layer_outputs), .layer_outputs_valid(s_layer_outputs_valid),
    .layer_outputs_ready(s_layer_outputs_ready),
    .layer_inputs(s_layer_inputs), .layer_inputs_valid(s_layer_inputs_valid),
    .layer_inputs_ready(s_layer_inputs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference activation: interpret raw as signed `now` bits, clamp to [0, 2^aw-1].
  function automatic int unsigned act_of(input int unsigned raw, input int now, input int aw);
    longint s;
    longint lim;
    s   = (raw >= (32'd1 << (now - 1))) ? longint'(raw) - (longint'(1) << now) : longint'(raw);
    lim = (longint'(1) << aw) - 1;
    if (s < 0)   return 0;
    if (s > lim) return int'(lim);
    return int'(s);
  endfunction

  function automatic logic [NN*NOW-1:0] pack_model();
    logic [NN*NOW-1:0] v;
    v = '0;
    for (int i = 0; i < NN; i++) v[i*NOW +: NOW] = NOW'(model_act[i]);
    return v;
  endfunction

  function automatic logic hs_flag(input int ch);
    case (ch)
      0:       return start_inputs_ready;
      1:       return layer_number_ready;
      2:       return layer_inputs_valid;
      default: return layer_outputs_ready;
    endcase
  endfunction

  // Waits (bounded) for the DUT side of channel ch, then lets the transfer edge pass.
  task automatic wait_xfer(input int ch, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (hs_flag(ch)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, ok, 1'b1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One input vector through all LMAX layers; model_act holds the start lanes.
  task automatic run_vector(input bit directed);
    int unsigned raw [NN];
    int base;
    logic [NN*NOW-1:0] expv;
    for (int i = 0; i < NN; i++) start_inputs[i*AW +: AW] = AW'(model_act[i]);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    start_inputs_valid = 1'b1;
    wait_xfer(0, "start_xfer");
    start_inputs_valid = 1'b0;
    start_inputs = NN*AW'($urandom);
    base = li_xfers;
    for (int l = 0; l < LMAX; l++) begin
      for (int i = 0; i < NN; i++)
        raw[i] = (directed && l == 0) ? dir_raw[i] : $urandom_range(0, (1 << NOW) - 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      layer_number = LAW'($urandom);
      layer_number_valid = 1'b1;
      wait_xfer(1, "layer_xfer");
      layer_number_valid = 1'b0;
      expv = pack_model();
      if (directed && l == 0) begin
        chk("li_start_lanes", layer_inputs, {10'd1, 10'd2, 10'd3, 10'd4, 10'd5});
        for (int i = 0; i < NN; i++) layer_outputs[i*NOW +: NOW] = NOW'(raw[i]);
        layer_outputs_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("bp_valid", layer_inputs_valid, 1'b1);
          chk("bp_data", layer_inputs, expv);
          chk("bp_lo_ready", layer_outputs_ready, 1'b0);
        end
      end else begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk("stall_valid", layer_inputs_valid, 1'b1);
          chk("stall_data", layer_inputs, expv);
        end
      end
      if (directed && l == 1)
        chk("li_relu_lanes", layer_inputs, {10'd476, 10'd0, 10'd452, 10'd0, 10'd428});
      chk("li_valid", layer_inputs_valid, 1'b1);
      chk("li_data", layer_inputs, expv);
      layer_inputs_ready = 1'b1;
      wait_xfer(2, "li_xfer");
      layer_inputs_ready = 1'b0;
      for (int i = 0; i < NN; i++) layer_outputs[i*NOW +: NOW] = NOW'(raw[i]);
      layer_outputs_valid = 1'b1;
      wait_xfer(3, "lo_xfer");
      layer_outputs_valid = 1'b0;
      layer_outputs = NN*NOW'($urandom);
      for (int i = 0; i < NN; i++) model_act[i] = act_of(raw[i], NOW, AW);
    end
    chk("li_count", li_xfers - base, LMAX);
    chk("idle_ready", start_inputs_ready, 1'b1);
    chk("idle_li_valid", layer_inputs_valid, 1'b0);
    chk("final_lanes", layer_inputs, pack_model());
  endtask

  always @(posedge clk) begin
    if (layer_inputs_valid && layer_inputs_ready) li_xfers <= li_xfers + 1;
  end

  always @(negedge clk) begin
    if (!rst)
      chk("onehot", $countones({start_inputs_ready, layer_number_ready,
                               layer_inputs_valid, layer_outputs_ready}) == 1, 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NN*SNOW-1:0] s_exp;
    int unsigned s_raw [NN];
    bit ok;
    int base;

    rst = 1'b1;
    start_inputs = '0;  start_inputs_valid = 1'b0;
    layer_number = '0;  layer_number_valid = 1'b0;
    layer_outputs = '0; layer_outputs_valid = 1'b0;
    layer_inputs_ready = 1'b0;
    s_start_inputs = '0;  s_start_inputs_valid = 1'b0;
    s_layer_number = '0;  s_layer_number_valid = 1'b0;
    s_layer_outputs = '0; s_layer_outputs_valid = 1'b0;
    s_layer_inputs_ready = 1'b0;

    // Reset held for 5 cycles.
    repeat (5) begin
      @(negedge clk);
      chk("rst_handshakes", {start_inputs_ready, layer_number_ready,
                             layer_inputs_valid, layer_outputs_ready}, 4'b0000);
      chk("rst_li", layer_inputs, '0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready", start_inputs_ready, 1'b1);

    // Directed start {5,4,3,2,1} with backpressure and ReLU pattern.
    model_act = '{5, 4, 3, 2, 1};
    run_vector(1'b1);

    // Second vector restarts cleanly, then randomized vectors.
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < NN; i++) model_act[i] = $urandom_range(0, (1 << AW) - 1);
      run_vector(1'b0);
    end

    // Reset during SEND with a simultaneous layer_inputs_ready.
    for (int i = 0; i < NN; i++) model_act[i] = $urandom_range(1, (1 << AW) - 1);
    for (int i = 0; i < NN; i++) start_inputs[i*AW +: AW] = AW'(model_act[i]);
    start_inputs_valid = 1'b1;
    wait_xfer(0, "mr_start_xfer");
    start_inputs_valid = 1'b0;
    layer_number_valid = 1'b1;
    wait_xfer(1, "mr_layer_xfer");
    layer_number_valid = 1'b0;
    base = li_xfers;
    rst = 1'b1;
    layer_inputs_ready = 1'b1;
    @(negedge clk);
    chk("mr_rst_handshakes", {start_inputs_ready, layer_number_ready,
                              layer_inputs_valid, layer_outputs_ready}, 4'b0000);
    @(posedge clk);
    #1;
    chk("mr_li_cleared", layer_inputs, '0);
    rst = 1'b0;
    layer_inputs_ready = 1'b0;
    #1;
    chk("mr_idle_ready", start_inputs_ready, 1'b1);
    chk("mr_no_xfer", li_xfers - base, 0);
    for (int i = 0; i < NN; i++) model_act[i] = $urandom_range(0, (1 << AW) - 1);
    run_vector(1'b0);

    // Saturation on the 12-bit build (single layer).
    s_raw = '{1000, 511, 512, 4095, 300};
    for (int i = 0; i < NN; i++) s_layer_outputs[i*SNOW +: SNOW] = SNOW'(s_raw[i]);
    s_exp = '0;
    for (int i = 0; i < NN; i++) s_exp[i*SNOW +: SNOW] = SNOW'(act_of(s_raw[i], SNOW, AW));
    s_start_inputs = NN*AW'($urandom);
    s_layer_number_valid = 1'b1;
    s_layer_inputs_ready = 1'b1;
    s_layer_outputs_valid = 1'b1;
    @(negedge clk);
    chk("sat_idle_ready", s_start_inputs_ready, 1'b1);
    s_start_inputs_valid = 1'b1;
    @(posedge clk);
    #1;
    s_start_inputs_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_start_inputs_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sat_done", ok, 1'b1);
    chk("sat_lane0_1000", s_layer_inputs[SNOW-1:0], 511);
    chk("sat_lanes", s_layer_inputs, s_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
